inst_fetch: RTL

//  Instruction fetch stage upstream of the dual-port instruction/data cache. Holds the PC, issues paired

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fetch_queue.sv | 53 +++++
 rtl/inst_fetch.sv | 85 ++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its queue.
package inst_fetch_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    localparam word_t ZERO         = '0;
    localparam addr_t NULL_PTR     = '0;
    localparam int    INST_QUEUE_W = 3;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_RESP = 1'b1
    } fetch_state_e;

    typedef struct packed {
        word_t inst;
        addr_t pc;
    } qentry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue: up to two in-order writes and one fall-through read per cycle.
module inst_fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int QW = INST_QUEUE_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic [1:0]    enq_n,
    input  qentry_t       enq0,
    input  qentry_t       enq1,
    input  logic          deq_ready,
    output logic          deq_valid,
    output qentry_t       deq_entry,
    output logic [QW:0]   count
);
    localparam int DEPTH = 2 ** QW;
    localparam logic [QW-1:0] ONE = 1;

    qentry_t        mem [DEPTH];
    logic [QW-1:0]  head;
    logic [QW-1:0]  tail;
    logic           pop;

    assign deq_valid = (count != '0);
    assign deq_entry = mem[head];
    assign pop       = deq_valid && deq_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '{inst: ZERO, pc: NULL_PTR};
        end else if (en) begin
            if (flush) begin
                // A redirect drops everything: queued entries, this cycle's pop and any enqueue.
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq_n != 2'd0) mem[tail] <= enq0;
                if (enq_n == 2'd2) mem[tail + ONE] <= enq1;
                tail  <= tail + QW'(enq_n);
                if (pop) head <= head + ONE;
                count <= count + (QW+1)'(enq_n) - (QW+1)'(pop);
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC register and two-state request/response FSM issuing paired cache lookups.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int    QUEUE_WIDTH = INST_QUEUE_W,
    parameter addr_t RESET_PC    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        redirect_valid,
    input  addr_t       redirect_pc,
    output logic        en_rx,
    output addr_t       pcx,
    input  logic        hitx,
    input  word_t       instx,
    output logic        en_ry,
    output addr_t       pcy,
    input  logic        hity,
    input  word_t       insty,
    input  logic        deq_ready,
    output logic        deq_valid,
    output word_t       deq_inst,
    output addr_t       deq_pc
);
    localparam int QUEUE_DEPTH = 2 ** QUEUE_WIDTH;
    // Issue only when two slots are free, so a double hit can never overflow.
    localparam logic [QUEUE_WIDTH:0] FREE_LIM = (QUEUE_WIDTH+1)'(QUEUE_DEPTH - 2);

    fetch_state_e           state;
    addr_t                  pc;
    logic [QUEUE_WIDTH:0]   count;
    logic [1:0]             enq_n;
    qentry_t                head_entry;

    assign pcx   = pc;
    assign pcy   = pc + 32'd4;
    assign en_rx = (state == S_REQ) && (count <= FREE_LIM);
    assign en_ry = en_rx;

    always_comb begin
        enq_n = 2'd0;
        if (state == S_RESP && hitx) enq_n = hity ? 2'd2 : 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= S_REQ;
        end else if (rdy) begin
            if (redirect_valid) begin
                pc    <= redirect_pc;
                state <= S_REQ;
            end else begin
                case (state)
                    S_REQ: if (en_rx) state <= S_RESP;
                    S_RESP: begin
                        state <= S_REQ;
                        // A port X miss keeps pc so the same line is re-requested until refilled.
                        if (hitx) pc <= pc + (hity ? 32'd8 : 32'd4);
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end

    inst_fetch_queue #(.QW(QUEUE_WIDTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .flush     (redirect_valid),
        .enq_n     (enq_n),
        .enq0      ('{inst: instx, pc: pc}),
        .enq1      ('{inst: insty, pc: pcy}),
        .deq_ready (deq_ready),
        .deq_valid (deq_valid),
        .deq_entry (head_entry),
        .count     (count)
    );

    assign deq_inst = head_entry.inst;
    assign deq_pc   = head_entry.pc;

endmodule
